// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Holds the fetch PC, reads instruction memory over a req/ack handshake and
// prefetches into a 2-entry in-order queue whose head is presented downstream
// over a valid/ready handshake. A taken branch on the head instruction is
// applied when that instruction is dequeued: target = head pc + signed offset.
// All queued and in-flight wrong-path fetches are discarded.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   imem_req/addr   fetch request and address (held until ack)
//   imem_ack/rdata  one-cycle acknowledge with the fetched instruction
//   instr_out/pc_out/instr_valid/instr_ready  queue head handshake
//   redirect/redirect_imm  taken branch on the head, offset
//   fetch_err       sticky misaligned-target error
//
// state | meaning
// FETCH | normal prefetch; request while queue has room
// FLUSH | wait out an abandoned request, discard its data
// ERR   | misaligned branch target; idle until reset
module fetch_unit #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_ack,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic [DATA_WIDTH-1:0]    instr_out,
    output logic [ADDRESS_WIDTH-1:0] pc_out,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     redirect,
    input  logic [DATA_WIDTH-1:0]    redirect_imm,
    output logic                     fetch_err
);

    typedef enum logic [1:0] {FETCH, FLUSH, ERR} state_t;

    state_t                    state;
    logic [ADDRESS_WIDTH-1:0]  fetch_pc;
    logic [ADDRESS_WIDTH-1:0]  addr_q;
    logic                      req_q;
    logic                      err_q;
    logic [1:0]                count;
    logic [DATA_WIDTH-1:0]     q_instr [2];
    logic [ADDRESS_WIDTH-1:0]  q_pc    [2];

    logic                      deq;
    logic                      ack;
    logic                      enq;
    logic                      do_redir;
    logic [ADDRESS_WIDTH-1:0]  imm_a;
    logic [ADDRESS_WIDTH-1:0]  target;
    logic [ADDRESS_WIDTH-1:0]  next_pc;
    logic [1:0]                deq_count;
    logic [1:0]                cnt_next;

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = (count != 2'd0);
    assign instr_out   = q_instr[0];
    assign pc_out      = q_pc[0];
    assign fetch_err   = err_q;

    assign deq       = instr_valid & instr_ready;
    // an ack only means something while a request is actually up
    assign ack       = imem_ack & req_q;
    assign enq       = ack & (state == FETCH);
    assign do_redir  = deq & redirect;
    assign imm_a     = ADDRESS_WIDTH'($signed(redirect_imm));
    assign target    = pc_out + imm_a;
    assign next_pc   = fetch_pc + ADDRESS_WIDTH'(4);
    assign deq_count = count - {1'b0, deq};
    assign cnt_next  = deq_count + {1'b0, enq};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            fetch_pc   <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            err_q      <= 1'b0;
            count      <= 2'd0;
            q_instr[0] <= '0;
            q_instr[1] <= '0;
            q_pc[0]    <= '0;
            q_pc[1]    <= '0;
        end else if (state != ERR) begin
            if (do_redir) begin
                count    <= 2'd0;
                fetch_pc <= target;
                if (target[1:0] != 2'b00) begin
                    state <= ERR;
                    req_q <= 1'b0;
                    err_q <= 1'b1;
                end else if (req_q && !imem_ack) begin
                    // request stays up with its old address until the memory answers
                    state <= FLUSH;
                end else begin
                    state  <= FETCH;
                    req_q  <= 1'b1;
                    addr_q <= target;
                end
            end else begin
                if (deq) begin
                    q_instr[0] <= q_instr[1];
                    q_pc[0]    <= q_pc[1];
                end
                // an ack only arrives with count<=1, so the slot index fits in one bit;
                // this write follows the shift so it wins when both hit entry 0
                if (enq) begin
                    q_instr[deq_count[0]] <= imem_rdata;
                    q_pc[deq_count[0]]    <= fetch_pc;
                end
                count <= cnt_next;
                if (state == FETCH) begin
                    if (ack) fetch_pc <= next_pc;
                    if (!req_q || ack) begin
                        req_q  <= (cnt_next != 2'd2);
                        addr_q <= ack ? next_pc : fetch_pc;
                    end
                end else if (ack) begin
                    state  <= FETCH;
                    req_q  <= 1'b1;
                    addr_q <= fetch_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack, instr_valid, instr_ready, redirect, fetch_err;
    logic [31:0] imem_addr, imem_rdata, instr_out, pc_out, redirect_imm;

    logic        req2, ack2, valid2, err2;
    logic [31:0] addr2, rdata2, instr2, pc2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_out(instr_out),
        .pc_out(pc_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_imm(redirect_imm), .fetch_err(fetch_err));

    fetch_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2), .instr_out(instr2),
        .pc_out(pc2), .instr_valid(valid2), .instr_ready(1'b1),
        .redirect(1'b0), .redirect_imm(32'h0), .fetch_err(err2));

    // memory contents: word index + 0x100
    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h100 + (a >> 2);
    endfunction

    // environment / reference-model state
    int          lat = 1;
    int          ready_pct = 100;
    int          redir_pct = 0;
    int          wait_cnt;
    int          n_acks, n_consumed;
    logic        prev_pending;
    logic [31:0] prev_addr;
    logic [31:0] exp_pc;
    logic        have_exp_req;
    logic [31:0] exp_req_addr;
    logic        redir_armed;
    logic [31:0] redir_pc, redir_imm;
    logic        err_exp;
    logic [31:0] ack_log [$];
    int          d2_n;
    logic [31:0] d2_addr [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic env_reset();
        imem_ack = 0; imem_rdata = 0; instr_ready = 0; redirect = 0; redirect_imm = 0;
        ack2 = 0; rdata2 = 0;
        wait_cnt = 0; n_acks = 0; n_consumed = 0;
        prev_pending = 0; prev_addr = 0;
        exp_pc = 32'h0; have_exp_req = 1; exp_req_addr = 32'h0;
        redir_armed = 0; err_exp = 0; redir_pct = 0;
        ack_log.delete(); d2_n = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        env_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    // one clock: sample outputs #1 after the edge, then drive this cycle's inputs
    task automatic cycle();
        logic        ack, rdy, rd;
        logic [31:0] imm, tgt;
        @(posedge clk); #1;
        if (prev_pending) begin
            chk("req_hold", {31'b0, imem_req}, 32'd1);
            chk("addr_hold", imem_addr, prev_addr);
        end else if (imem_req && have_exp_req) begin
            chk("new_fetch_addr", imem_addr, exp_req_addr);
            have_exp_req = 0;
        end
        ack = 0;
        if (imem_req) begin
            wait_cnt++;
            if (wait_cnt >= lat) begin
                ack = 1; wait_cnt = 0; n_acks++;
                ack_log.push_back(imem_addr);
            end
        end
        imem_ack   = ack;
        imem_rdata = ack ? mem(imem_addr) : $urandom;
        prev_pending = imem_req && !ack;
        prev_addr    = imem_addr;

        rdy = ($urandom_range(0, 99) < ready_pct);
        rd = 0; imm = 0;
        if (instr_valid && rdy) begin
            chk("head_pc", pc_out, exp_pc);
            chk("head_instr", instr_out, mem(exp_pc));
            n_consumed++;
            if (redir_armed && pc_out == redir_pc) begin
                rd = 1; imm = redir_imm; redir_armed = 0;
            end else if ($urandom_range(0, 99) < redir_pct) begin
                rd = 1; imm = 32'((int'($urandom_range(0, 32)) - 16) * 4);
            end
            if (rd) begin
                tgt = exp_pc + imm;
                exp_pc = tgt;
                if (tgt[1:0] != 0) err_exp = 1;
                else begin have_exp_req = 1; exp_req_addr = tgt; end
            end else begin
                exp_pc = exp_pc + 4;
            end
        end
        instr_ready  = rdy;
        redirect     = rd;
        redirect_imm = rd ? imm : $urandom;

        if (req2 && d2_n < 2) begin d2_addr[d2_n] = addr2; d2_n++; end
        ack2   = req2;
        rdata2 = mem(addr2);
    endtask

    initial begin
        int k;
        // reset values
        env_reset();
        #12;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_err", {31'b0, fetch_err}, 32'd0);
        chk("rst_addr2", addr2, 32'hFFFF_FFFC);

        // streaming, 1-cycle memory, ready=1
        do_reset(); lat = 1; ready_pct = 100;
        k = 0;
        while (!instr_valid && k < 10) begin cycle(); k++; end
        chk("t1_valid_seen", {31'b0, instr_valid}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            cycle();
            chk("t1_valid_stream", {31'b0, instr_valid}, 32'd1);
        end
        chk("t1_ack_log_len", {31'b0, ack_log.size() >= 5}, 32'd1);
        for (int i = 0; i < 5 && i < ack_log.size(); i++)
            chk("t1_fetch_addr", ack_log[i], 32'(i * 4));
        chk("t1_consumed", {31'b0, n_consumed >= 10}, 32'd1);
        chk("wrap_d2_n", d2_n, 2);
        chk("wrap_addr0", d2_addr[0], 32'hFFFF_FFFC);
        chk("wrap_addr1", d2_addr[1], 32'h0);

        // consumer stalled from reset
        do_reset(); lat = 1; ready_pct = 0;
        repeat (8) cycle();
        chk("t2_req_low", {31'b0, imem_req}, 32'd0);
        chk("t2_valid", {31'b0, instr_valid}, 32'd1);
        chk("t2_head_pc", pc_out, 32'h0);
        chk("t2_acks", n_acks, 2);
        ready_pct = 100;
        repeat (10) cycle();
        chk("t2_consumed", {31'b0, n_consumed >= 3}, 32'd1);

        // slow memory, forward redirect
        do_reset(); lat = 3; ready_pct = 100;
        redir_armed = 1; redir_pc = 32'h8; redir_imm = 32'h20;
        repeat (60) cycle();
        chk("t3_redirect_taken", {31'b0, redir_armed}, 32'd0);
        chk("t3_target_fetched", {31'b0, have_exp_req}, 32'd0);
        chk("t3_progress", {31'b0, exp_pc > 32'h2C}, 32'd1);

        // backward redirect with 1-cycle memory
        do_reset(); lat = 1; ready_pct = 100;
        redir_armed = 1; redir_pc = 32'h10; redir_imm = 32'hFFFF_FFF8;
        repeat (30) cycle();
        chk("t4_redirect_taken", {31'b0, redir_armed}, 32'd0);
        chk("t4_target_fetched", {31'b0, have_exp_req}, 32'd0);

        // misaligned target
        do_reset(); lat = 1; ready_pct = 100;
        redir_armed = 1; redir_pc = 32'hC; redir_imm = 32'h2;
        k = 0;
        while (!err_exp && k < 30) begin cycle(); k++; end
        chk("t5_redirect_seen", {31'b0, err_exp}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("t5_err", {31'b0, fetch_err}, 32'd1);
            chk("t5_req", {31'b0, imem_req}, 32'd0);
            chk("t5_valid", {31'b0, instr_valid}, 32'd0);
        end
        rst_n = 0; #1;
        chk("t5_rst_err", {31'b0, fetch_err}, 32'd0);
        chk("t5_rst_req", {31'b0, imem_req}, 32'd0);
        chk("t5_rst_valid", {31'b0, instr_valid}, 32'd0);

        // asynchronous reset in the middle of a pending request
        do_reset(); lat = 3; ready_pct = 100;
        repeat (7) cycle();
        #3; rst_n = 0; #1;
        chk("t6_req", {31'b0, imem_req}, 32'd0);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_valid", {31'b0, instr_valid}, 32'd0);
        chk("t6_instr", instr_out, 32'h0);
        chk("t6_pc", pc_out, 32'h0);
        chk("t6_err", {31'b0, fetch_err}, 32'd0);
        do_reset(); lat = 1;
        k = 0;
        while (!imem_req && k < 5) begin cycle(); k++; end
        chk("t6_first_req", {31'b0, imem_req}, 32'd1);
        chk("t6_first_addr", imem_addr, 32'h0);
        repeat (10) cycle();

        // randomized traffic with aligned redirects
        for (int p = 0; p < 4; p++) begin
            do_reset();
            lat = $urandom_range(1, 3);
            ready_pct = 60;
            redir_pct = 15;
            repeat (300) cycle();
            chk("rand_progress", {31'b0, n_consumed > 20}, 32'd1);
            chk("rand_no_err", {31'b0, fetch_err}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
